// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 window generator and its consumers.
// Provides the default pixel width, window position indices (raster order,
// 1 = top-left, 5 = centre, 9 = bottom-right) and a counter-width helper.
package filter_pkg;

  localparam int DATA_W_DEF = 8;

  localparam int WIN_TL = 1;
  localparam int WIN_TC = 2;
  localparam int WIN_TR = 3;
  localparam int WIN_ML = 4;
  localparam int WIN_C  = 5;
  localparam int WIN_MR = 6;
  localparam int WIN_BL = 7;
  localparam int WIN_BC = 8;
  localparam int WIN_BR = 9;

  // Bits needed to count 0..n-1; never less than 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line store: one address shared by read and write.
// Read is combinational and returns the old contents when written in the same
// cycle (read-before-write). Contents are not reset.
// Ports: clk, we_i (write enable), addr_i, wdata_i, rdata_o.
module line_buffer #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 8,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/sliding_window_3x3.sv
// Raster-to-3x3-window generator feeding the pixel filter.
// Latency: window and act registered, 1 cycle after the qualifying beat.
// No backpressure: a beat may be accepted every cycle; en/pix_valid low holds all state.
// Optional macro SOF_RESYNC_EN adds the sof input: an accepted sof beat is forced to (0,0).
// Ports: clk, rst_n (sync, active-low), en, pix_valid, pix_in, [sof],
//        sw_pixels1..9 (window, 1 = top-left .. 9 = bottom-right), act, frame_done.
module sliding_window_3x3
  import filter_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_in,
`ifdef SOF_RESYNC_EN
  input  logic              sof,
`endif
  output logic [DATA_W-1:0] sw_pixels1,
  output logic [DATA_W-1:0] sw_pixels2,
  output logic [DATA_W-1:0] sw_pixels3,
  output logic [DATA_W-1:0] sw_pixels4,
  output logic [DATA_W-1:0] sw_pixels5,
  output logic [DATA_W-1:0] sw_pixels6,
  output logic [DATA_W-1:0] sw_pixels7,
  output logic [DATA_W-1:0] sw_pixels8,
  output logic [DATA_W-1:0] sw_pixels9,
  output logic              act,
  output logic              frame_done
);

  localparam int CW = cnt_width(IMG_W);
  localparam int RW = cnt_width(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic              accept;
  logic [CW-1:0]     col_q, col_d, col_cur;
  logic [RW-1:0]     row_q, row_d, row_cur;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic              win_vld, last_beat;

  // Two left-hand window columns kept from earlier beats; index 0 = top.
  logic [DATA_W-1:0] lcol_q [3];
  logic [DATA_W-1:0] mcol_q [3];
  logic [DATA_W-1:0] win_d  [1:9];
  logic [DATA_W-1:0] sw_q   [1:9];
  logic              act_q, fd_q;

  assign accept = en && pix_valid && rst_n;

  // Position of the current beat; a resync beat is treated as (0,0).
`ifdef SOF_RESYNC_EN
  assign col_cur = sof ? '0 : col_q;
  assign row_cur = sof ? '0 : row_q;
`else
  assign col_cur = col_q;
  assign row_cur = row_q;
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
        row_d = row_cur;
      end
    end
  end

  // lb0 holds the previous row, lb1 the one before; lb0's old value cascades into lb1.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_cur),
    .wdata_i (pix_in),
    .rdata_o (lb0_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W), .AW(CW)) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_cur),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Window as it stands after this beat's left shift.
  always_comb begin
    win_d[WIN_TL] = lcol_q[0];
    win_d[WIN_TC] = mcol_q[0];
    win_d[WIN_TR] = lb1_rd;
    win_d[WIN_ML] = lcol_q[1];
    win_d[WIN_C]  = mcol_q[1];
    win_d[WIN_MR] = lb0_rd;
    win_d[WIN_BL] = lcol_q[2];
    win_d[WIN_BC] = mcol_q[2];
    win_d[WIN_BR] = pix_in;
  end

  // Columns 0/1 of each row carry stale neighbours, so only interior beats qualify.
  assign win_vld   = accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
  assign last_beat = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      act_q <= 1'b0;
      fd_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        lcol_q[i] <= '0;
        mcol_q[i] <= '0;
      end
      for (int i = 1; i <= 9; i++) sw_q[i] <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      act_q <= win_vld;
      fd_q  <= win_vld && last_beat;
      if (accept) begin
        lcol_q[0] <= mcol_q[0];
        lcol_q[1] <= mcol_q[1];
        lcol_q[2] <= mcol_q[2];
        mcol_q[0] <= lb1_rd;
        mcol_q[1] <= lb0_rd;
        mcol_q[2] <= pix_in;
      end
      if (win_vld) begin
        for (int i = 1; i <= 9; i++) sw_q[i] <= win_d[i];
      end
    end
  end

  assign sw_pixels1 = sw_q[WIN_TL];
  assign sw_pixels2 = sw_q[WIN_TC];
  assign sw_pixels3 = sw_q[WIN_TR];
  assign sw_pixels4 = sw_q[WIN_ML];
  assign sw_pixels5 = sw_q[WIN_C];
  assign sw_pixels6 = sw_q[WIN_MR];
  assign sw_pixels7 = sw_q[WIN_BL];
  assign sw_pixels8 = sw_q[WIN_BC];
  assign sw_pixels9 = sw_q[WIN_BR];
  assign act        = act_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Self-checking bench for sliding_window_3x3 on a 4x4 image.
// Pixel at (r,c) of a frame is base + r*16 + c; windows are compared against that image.
// Optional SOF_RESYNC_EN scenario is exercised when the macro is defined.
module tb_sliding_window_3x3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pix_valid;
  logic [7:0] pix_in;
`ifdef SOF_RESYNC_EN
  logic       sof;
`endif
  logic [7:0] sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9;
  logic       act, frame_done;
  wire [71:0] sw_all = {sw1, sw2, sw3, sw4, sw5, sw6, sw7, sw8, sw9};

  int errors = 0;
  int checks = 0;
  logic [72:0] got_q[$];

  always #5 clk = ~clk;

  sliding_window_3x3 #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .pix_valid  (pix_valid),
    .pix_in     (pix_in),
`ifdef SOF_RESYNC_EN
    .sof        (sof),
`endif
    .sw_pixels1 (sw1),
    .sw_pixels2 (sw2),
    .sw_pixels3 (sw3),
    .sw_pixels4 (sw4),
    .sw_pixels5 (sw5),
    .sw_pixels6 (sw6),
    .sw_pixels7 (sw7),
    .sw_pixels8 (sw8),
    .sw_pixels9 (sw9),
    .act        (act),
    .frame_done (frame_done)
  );

  // Record every signalled window with its frame_done flag.
  always @(negedge clk) begin
    if (act === 1'b1) got_q.push_back({frame_done, sw_all});
  end

  function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
    return base + 8'(r * 16 + c);
  endfunction

  // Expected window (plus frame_done) for k-th window (0..3) of a 4x4 frame.
  function automatic logic [72:0] exp_win(input logic [7:0] base, input int k);
    int r, c;
    r = 2 + k / 2;
    c = 2 + k % 2;
    return {(k == 3) ? 1'b1 : 1'b0,
            pix(base, r-2, c-2), pix(base, r-2, c-1), pix(base, r-2, c),
            pix(base, r-1, c-2), pix(base, r-1, c-1), pix(base, r-1, c),
            pix(base, r,   c-2), pix(base, r,   c-1), pix(base, r,   c)};
  endfunction

  // Drive one cycle of inputs; returns at the following falling edge.
  task automatic drive(input logic v, input logic e, input logic [7:0] p);
    pix_valid = v;
    en        = e;
    pix_in    = p;
`ifdef SOF_RESYNC_EN
    sof       = 1'b0;
`endif
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'hA5);
      checks++;
      if ({act, frame_done, sw_all} !== 74'h0)
        $display("FAIL reset_outputs cycle %0d: got act=%b fd=%b sw=%h, want all zero",
                 i, act, frame_done, sw_all);
      if ({act, frame_done, sw_all} !== 74'h0) errors++;
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
  endtask

  task automatic test_basic();
    int early;
    logic [72:0] e;
    early = 0;
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, pix(8'h00, i / 4, i % 4));
      if (i == 10) begin
        e = exp_win(8'h00, 0);
        checks++;
        if (act !== 1'b1 || sw_all !== e[71:0]) begin
          errors++;
          $display("FAIL basic_first_act: got act=%b sw=%h, want act=1 sw=%h", act, sw_all, e[71:0]);
        end
      end else if (i < 10 && act !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL basic_no_early_act: got %0d early pulses, want 0", early);
    end
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL basic_count: got %0d windows, want 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      e = exp_win(8'h00, k);
      checks++;
      if (got_q[k] !== e) begin
        errors++;
        $display("FAIL basic_win%0d: got %h, want %h", k, got_q[k], e);
      end
    end
  endtask

  task automatic test_gapped();
    logic [15:0] gap_pat;
    int gap_act;
    logic [72:0] e;
    gap_pat = 16'b0110_1001_0011_0110;
    gap_act = 0;
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      if (gap_pat[i]) begin
        drive(1'b0, 1'b1, 8'hEE);
        if (act !== 1'b0) gap_act++;
      end
      drive(1'b1, 1'b1, pix(8'h00, i / 4, i % 4));
      if (i == 9) begin
        for (int g = 0; g < 5; g++) begin
          drive(1'b1, 1'b0, 8'hDD);
          if (act !== 1'b0) gap_act++;
        end
      end
    end
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (gap_act != 0) begin
      errors++;
      $display("FAIL gapped_no_act_in_gap: got %0d pulses during gaps, want 0", gap_act);
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL gapped_count: got %0d windows, want 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      e = exp_win(8'h00, k);
      checks++;
      if (got_q[k] !== e) begin
        errors++;
        $display("FAIL gapped_win%0d: got %h, want %h", k, got_q[k], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [72:0] e;
    logic [7:0]  base;
    got_q.delete();
    for (int i = 0; i < 32; i++) begin
      base = (i < 16) ? 8'h00 : 8'h80;
      drive(1'b1, 1'b1, pix(base, (i % 16) / 4, i % 4));
      if (i == 26) begin
        e = exp_win(8'h80, 0);
        checks++;
        if (act !== 1'b1 || sw_all !== e[71:0]) begin
          errors++;
          $display("FAIL b2b_first_act_B: got act=%b sw=%h, want act=1 sw=%h", act, sw_all, e[71:0]);
        end
      end
    end
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("FAIL b2b_count: got %0d windows, want 8", got_q.size());
    end
    for (int k = 0; k < 8 && k < got_q.size(); k++) begin
      e = exp_win((k < 4) ? 8'h00 : 8'h80, k % 4);
      checks++;
      if (got_q[k] !== e) begin
        errors++;
        $display("FAIL b2b_win%0d: got %h, want %h", k, got_q[k], e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad_act;
    logic [72:0] e;
    bad_act = 0;
    got_q.delete();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, pix(8'h30, i / 4, i % 4));
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 8'h77);
      if (act !== 1'b0) bad_act++;
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 8'h00);
    if (act !== 1'b0) bad_act++;
    checks++;
    if (bad_act != 0) begin
      errors++;
      $display("FAIL midrst_no_act: got %0d pulses around reset, want 0", bad_act);
    end
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, pix(8'h40, i / 4, i % 4));
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL midrst_count: got %0d windows, want 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      e = exp_win(8'h40, k);
      checks++;
      if (got_q[k] !== e) begin
        errors++;
        $display("FAIL midrst_win%0d: got %h, want %h", k, got_q[k], e);
      end
    end
  endtask

`ifdef SOF_RESYNC_EN
  task automatic test_sof_resync();
    logic [72:0] e;
    got_q.delete();
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, pix(8'h10, i / 4, i % 4));
    // sof on a non-accepted beat must be ignored
    pix_valid = 1'b0; en = 1'b1; pix_in = 8'h55; sof = 1'b1;
    @(negedge clk);
    // 10th accepted beat carries sof and starts the new frame
    pix_valid = 1'b1; en = 1'b1; pix_in = pix(8'hA0, 0, 0); sof = 1'b1;
    @(negedge clk);
    for (int i = 1; i < 16; i++) drive(1'b1, 1'b1, pix(8'hA0, i / 4, i % 4));
    drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h00);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL sof_count: got %0d windows, want 4", got_q.size());
    end
    for (int k = 0; k < 4 && k < got_q.size(); k++) begin
      e = exp_win(8'hA0, k);
      checks++;
      if (got_q[k] !== e) begin
        errors++;
        $display("FAIL sof_win%0d: got %h, want %h", k, got_q[k], e);
      end
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 8'h00;
`ifdef SOF_RESYNC_EN
    sof       = 1'b0;
`endif
    test_reset();
    test_basic();
    test_gapped();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef SOF_RESYNC_EN
    test_sof_resync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sliding_window_3x3.md
Name: sliding_window_3x3

Overview:
- Raster-to-window generator that feeds the 3x3 pixel filter. It accepts one 8-bit pixel per valid beat in row-major order.
- Holds the two previous image rows in line buffers and a 3x3 shift-register window.
- Emits one complete 3x3 neighbourhood (sw_pixels1..9) with an act strobe for every interior pixel position.
- Outputs connect directly to the filter's window, act and en inputs.

Parameters:
- IMG_W, 256, pixels per row (>=3)
- IMG_H, 256, rows per frame (>=3)
- DATA_W, 8, pixel width in bits

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  block enable; when low, all input beats are ignored and all state holds
- pix_valid  in  1  pix_in is valid this cycle
- pix_in  in  DATA_W  input pixel, row-major order, row 0 first
- sof  in  1  start-of-frame marker (present only with SOF_RESYNC_EN)
- sw_pixels1..sw_pixels9  out  DATA_W each  window, raster order: 1 = top-left, 5 = centre, 9 = bottom-right
- act  out  1  window valid, one-cycle strobe per window
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame

Behaviour:
- Accepted beat: en && pix_valid && rst_n. No backpressure; a beat can be accepted every cycle.
- Counters:
  - col runs 0..IMG_W-1; row runs 0..IMG_H-1.
  - On an accepted beat, col increments. At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0 and the next beat is row 0 of the next frame.
- Line buffers:
  - lb0 holds row r-1; lb1 holds row r-2. Each is IMG_W deep.
  - On an accepted beat at col c: read lb0[c] and lb1[c], then write lb1[c] <= lb0[c] and lb0[c] <= pix_in.
  - Read-before-write within the same cycle.
- Window shift: on an accepted beat the 3x3 window shifts left by one column. The new right column is {lb1[c], lb0[c], pix_in} (top to bottom).
- Window validity: the window is valid iff the accepted beat has row>=2 and col>=2.
  - Centre pixel (sw_pixels5) = image(row-1, col-1); sw_pixels9 = the current pixel.
- Latency: sw_pixels1..9 and act are registered and appear 1 cycle after the qualifying beat.
  - act is high for exactly that cycle and low otherwise.
  - sw_pixels hold their last value while act is low.
- Window count: exactly (IMG_W-2)*(IMG_H-2) act pulses per frame, no padding. The columns at c=0,1 carry stale data from the previous row; they are never used because act is gated by col>=2.
- frame_done: asserted with the act of the window whose beat is (IMG_H-1, IMG_W-1).
- en low or pix_valid low mid-row: counters, line buffers and window hold; act=0. Gaps do not alter window contents.
- Reset:
  - All outputs are 0 and the counters are 0.
  - Line buffer contents are not cleared; they are don't-care because of the row gating.
  - Reset mid-frame discards the partial frame; the next accepted beat is (0,0).
- Back-to-back frames: line buffers still hold previous-frame data at rows 0..1. Row gating guarantees no cross-frame window is ever signalled.

Optional Feature:
- SOF_RESYNC_EN defined:
  - The sof port exists.
  - An accepted beat with sof=1 is forced to (row 0, col 0) regardless of the counter state, and the partial frame is discarded.
  - sof on a beat that is not accepted is ignored.
- SOF_RESYNC_EN not defined: no sof port; frame alignment is purely count-based.

Decomposition:
- Shared package (filter_pkg):
  - DATA_W default
  - Window index constants WIN_TL=1 .. WIN_BR=9
  - Counter width function clog2(IMG_W) / clog2(IMG_H)
- Sub-module line_buffer:
  - Parameterised depth and width.
  - Single address port, read-before-write, write enable.
  - Instantiated twice.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with pix_valid=1 -> all sw_pixels=0x00, act=0, frame_done=0 throughout.
- Basic frame: IMG_W=4, IMG_H=4, pixel=row*16+col, streamed every cycle -> exactly 4 act pulses.
  - First act comes 1 cycle after pixel 0x22, with sw1..9 = 00,01,02,10,11,12,20,21,22.
  - Last window has sw5=0x22, sw9=0x33, with frame_done=1.
- Gapped input: same frame with pix_valid toggled randomly and en low for 5 cycles mid-row 2 -> the identical 4 windows in the same order, with act never asserted during gaps.
- Back-to-back frames: frame A = 0x00+idx, frame B = 0x80+idx, with no gap between them.
  - B's first act comes after B pixel (2,2), and every window sw value is >=0x80.
  - Total act count = 8.
- Reset mid-frame: rst_n=0 after 7 accepted beats, then a full frame -> exactly 4 act pulses with correct values; no act during or right after reset.
- SOF_RESYNC_EN: sof=1 on the 10th beat of a frame, followed by 16 beats -> windows computed from the new frame only (4 act pulses), and frame_done on its last window.
